serial_word_tx: RTL and testbench

Transmitter for the LSB-first serial two's-complement datapath. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, LSB first. Drives a word-start strobe that is high on bit 0 of every word, so the downstream serial complementer clears its "first one seen" state at each word boundary. It sits directly in front of the complementer's serial bit input and word-start input, replacing hand-driven testbench stimulus.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/bit_counter.sv | 35 +++
 rtl/serial_word_tx.sv | 76 +++++++
 tb/tb_serial_word_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the LSB-first serial two's-complement datapath.
// Used by the word transmitter, the serial complementer and their benches.
//   DEFAULT_WIDTH : default word length in bits
//   state_t       : transmitter state encoding
//   SER_IDLE_I/R  : serial data / word-start levels driven while the line is idle
package serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // The complementer treats ser_r=1 as "hold in start state", so the idle
   // line parks data low and word-start high.
   localparam logic SER_IDLE_I = 1'b0;
   localparam logic SER_IDLE_R = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for the serial word transmitter.
// Counts 0..WIDTH-1 while enabled; clear has priority over enable.
//   clk, rst_n : clock, synchronous active-low reset (forces count to 0)
//   clear      : force count to 0 on the next edge
//   enable     : advance count by one on the next edge
//   cnt        : current bit index, $clog2(WIDTH) bits
//   at_last    : cnt is on the last bit of the word (WIDTH-1)
module bit_counter
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     enable,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     at_last
);

   localparam int CW = $clog2(WIDTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter feeding the serial complementer.
// Words are taken over a valid/ready handshake and shifted out LSB first,
// one bit per clock, with a word-start strobe on bit 0 of each word.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : upstream word available on in_data
//   in_ready   : a word can be accepted this cycle
//   in_data    : parallel word, bit 0 sent first
//   ser_i      : serial data bit to the complementer
//   ser_r      : word-start strobe to the complementer (high while idle)
//   busy       : a word is being shifted
//   word_done  : high while the last bit of a word is on ser_i
//
// state | meaning
// IDLE  | line parked (ser_i=0, ser_r=1), ready for a word
// SHIFT | shifting current word, cnt = index of bit on ser_i
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_i,
   output logic             ser_r,
   output logic             busy,
   output logic             word_done
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             at_last;
   logic             accept;
   logic             cnt_clear;

   // A new word can only enter on the last bit of the current one, which
   // gives gap-free back-to-back words without a holding register.
   assign in_ready  = rst_n && ((state == IDLE) || at_last);
   assign accept    = in_valid && in_ready;
   assign cnt_clear = accept || ((state == SHIFT) && at_last);

   bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear),
      .enable  (state == SHIFT),
      .cnt     (cnt),
      .at_last (at_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
      end else if (accept) begin
         state <= SHIFT;
         shreg <= in_data;
      end else if (state == SHIFT) begin
         shreg <= shreg >> 1;
         if (at_last) begin
            state <= IDLE;
         end
      end
   end

   assign busy      = (state == SHIFT);
   assign ser_i     = busy ? shreg[0] : SER_IDLE_I;
   assign ser_r     = busy ? (cnt == '0) : SER_IDLE_R;
   assign word_done = busy && at_last;

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;
   import serial_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v4, v8;
   logic [3:0] d4;
   logic [7:0] d8;
   logic       r4, i4, s4, b4, w4;
   logic       r8, i8, s8, b8, w8;

   serial_word_tx #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
      .ser_i(i4), .ser_r(s4), .busy(b4), .word_done(w4)
   );

   serial_word_tx #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8),
      .ser_i(i8), .ser_r(s8), .busy(b8), .word_done(w8)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Model: the word being sent and the index of the bit on the line (-1 = idle).
   int         wlen  [2] = '{4, 8};
   logic [7:0] m_word[2] = '{8'h00, 8'h00};
   int         m_pos [2] = '{-1, -1};
   bit         m_acc [2] = '{1'b0, 1'b0};

   function automatic logic exp_ready(int d);
      return rst_n && (m_pos[d] < 0 || m_pos[d] == wlen[d] - 1);
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic       v;
         logic [7:0] dat;
         logic       rdy;
         v   = (d == 0) ? v4 : v8;
         dat = (d == 0) ? {4'h0, d4} : d8;
         rdy = exp_ready(d);
         m_acc[d] = 1'b0;
         if (!rst_n) begin
            m_pos[d] = -1;
         end else if (v && rdy) begin
            m_word[d] = dat;
            m_pos[d]  = 0;
            m_acc[d]  = 1'b1;
         end else if (m_pos[d] >= 0) begin
            m_pos[d] = (m_pos[d] == wlen[d] - 1) ? -1 : m_pos[d] + 1;
         end
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            int   p;
            logic idle;
            p    = m_pos[d];
            idle = (p < 0);
            chk($sformatf("w%0d ser_i", wlen[d]), 16'((d == 0) ? i4 : i8),
                16'(idle ? 1'b0 : m_word[d][p]));
            chk($sformatf("w%0d ser_r", wlen[d]), 16'((d == 0) ? s4 : s8),
                16'(idle ? 1'b1 : (p == 0)));
            chk($sformatf("w%0d busy", wlen[d]), 16'((d == 0) ? b4 : b8), 16'(!idle));
            chk($sformatf("w%0d word_done", wlen[d]), 16'((d == 0) ? w4 : w8),
                16'(!idle && p == wlen[d] - 1));
            chk($sformatf("w%0d in_ready", wlen[d]), 16'((d == 0) ? r4 : r8),
                16'(exp_ready(d)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] bits, rs, rdys;
      logic       wd_seen, seen, cb;

      rst_n = 1'b0; v4 = 1'b0; v8 = 1'b0; d4 = '0; d8 = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset ser_i", 16'(i4), 16'(SER_IDLE_I));
      chk("reset ser_r", 16'(s4), 16'(SER_IDLE_R));
      chk("reset busy", 16'(b4), 16'd0);
      chk("reset word_done", 16'(w4), 16'd0);
      chk("reset in_ready", 16'(r4), 16'd1);

      // Single word 4'h5
      v4 = 1'b1; d4 = 4'h5;
      tick();
      v4 = 1'b0;
      bits = '0; rs = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bits[i] = i4; rs[i] = s4;
         if (i == 3) chk("single word_done last", 16'(w4), 16'd1);
      end
      chk("single ser_i", 16'(bits[3:0]), 16'h5);
      chk("single ser_r", 16'(rs[3:0]), 16'h1);
      @(negedge clk);
      chk("single idle ser_r", 16'(s4), 16'd1);
      chk("single idle ser_i", 16'(i4), 16'd0);

      // Back-to-back 4'h5 then 4'hB
      v4 = 1'b1; d4 = 4'h5;
      tick();
      d4 = 4'hB;
      bits = '0; rs = '0; rdys = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bits[i] = i4; rs[i] = s4; rdys[i] = r4;
         if (i == 3) begin
            tick();
            v4 = 1'b0;
         end
      end
      chk("b2b ser_i", 16'(bits), 16'h00B5);
      chk("b2b ser_r", 16'(rs), 16'h0011);
      chk("b2b in_ready", 16'(rdys), 16'h0088);
      @(negedge clk);

      // Backpressure: 4'hC offered during cycle 1 of 4'h5
      v4 = 1'b1; d4 = 4'h5;
      tick();
      v4 = 1'b0;
      bits = '0; rdys = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bits[i] = i4; rdys[i] = r4;
         if (i == 1) begin
            v4 = 1'b1; d4 = 4'hC;
         end
         if (i == 3) begin
            tick();
            v4 = 1'b0;
         end
      end
      chk("bp ser_i", 16'(bits), 16'h00C5);
      chk("bp in_ready", 16'(rdys), 16'h0088);
      @(negedge clk);

      // Mid-word reset on WIDTH=8 with 8'hA5
      v8 = 1'b1; d8 = 8'hA5;
      tick();
      v8 = 1'b0;
      bits = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bits[i] = i8;
      end
      chk("midrst first bits", 16'(bits[2:0]), 16'h5);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst in_ready low", 16'(r8), 16'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst ser_r", 16'(s8), 16'd1);
      chk("midrst ser_i", 16'(i8), 16'd0);
      chk("midrst busy", 16'(b8), 16'd0);
      wd_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         wd_seen = wd_seen | w8 | b8;
      end
      chk("midrst no residue", 16'(wd_seen), 16'd0);

      // End-to-end through a serial two's-complementer
      v8 = 1'b1; d8 = 8'h06;
      tick();
      v8 = 1'b0;
      bits = '0; seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cb   = s8 ? i8 : (i8 ^ seen);
         seen = (s8 ? 1'b0 : seen) | i8;
         bits[i] = cb;
      end
      chk("e2e complement", 16'(bits), 16'h00FA);
      @(negedge clk);

      // Randomized traffic, source holds each word until accepted
      for (int c = 0; c < 4000; c++) begin
         tick();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
         if (!v4 || m_acc[0]) begin
            v4 = ($urandom_range(0, 3) != 0);
            d4 = 4'($urandom);
         end
         if (!v8 || m_acc[1]) begin
            v8 = ($urandom_range(0, 3) != 0);
            d8 = 8'($urandom);
         end
      end
      v4 = 1'b0; v8 = 1'b0; rst_n = 1'b1;
      repeat (12) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
